// File: rtl/cmos_pixel_packer.sv
// Packs the CMOS sensor byte stream into whole pixels framed by VSYNC/HREF,
// tagging each pixel with x/y, sof/eol and flagging malformed lines/frames.
module cmos_pixel_packer #(
  parameter int DATA_W        = 8,
  parameter int BYTES_PER_PIX = 2,
  parameter int MSB_FIRST     = 1,
  parameter int H_ACTIVE      = 640,
  parameter int V_ACTIVE      = 480,
  localparam int XW           = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1,
  localparam int YW           = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1,
  localparam int PIX_W        = DATA_W * BYTES_PER_PIX
) (
  input  logic              CMOS_oCLK,
  input  logic              iRST_N,
  input  logic              CMOS_VSYNC,
  input  logic              CMOS_HREF,
  input  logic [DATA_W-1:0] DATA,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_valid,
  output logic [XW-1:0]     pix_x,
  output logic [YW-1:0]     pix_y,
  output logic              sof,
  output logic              eol,
  output logic              frame_done,
  output logic              line_err,
  output logic              frame_err
);

  localparam int PHW = (BYTES_PER_PIX > 1) ? $clog2(BYTES_PER_PIX) : 1;
  localparam logic [PHW-1:0] PH_LAST = PHW'(BYTES_PER_PIX - 1);
  localparam logic [XW:0]    X_LIM   = (XW+1)'(H_ACTIVE);
  localparam logic [XW:0]    X_LAST  = (XW+1)'(H_ACTIVE - 1);
  localparam logic [YW:0]    Y_LIM   = (YW+1)'(V_ACTIVE);

  typedef enum logic [1:0] {S_IDLE, S_VSYNC, S_FRAME} state_t;

  state_t            state_q, state_d;
  logic              vsync_q, href_q;
  logic [PHW-1:0]    phase_q, phase_d;
  logic [XW:0]       x_q, x_d;
  logic [YW:0]       y_q, y_d;
  logic              xovf_q, xovf_d;
  logic              yovf_q, yovf_d;
  logic              line_seen_q, line_seen_d;
  logic [PIX_W-1:0]  asm_q, asm_d, asm_shift;

  logic [PIX_W-1:0]  pix_data_q, pix_data_d;
  logic              pix_valid_q, pix_valid_d;
  logic [XW-1:0]     pix_x_q, pix_x_d;
  logic [YW-1:0]     pix_y_q, pix_y_d;
  logic              sof_q, sof_d, eol_q, eol_d;
  logic              frame_done_q, frame_done_d;
  logic              line_err_q, line_err_d;
  logic              frame_err_q, frame_err_d;

  logic vsync_rise, capture, line_end;

  generate
    if (BYTES_PER_PIX == 1) begin : g_single
      always_comb asm_shift = DATA;
    end else if (MSB_FIRST != 0) begin : g_msb
      always_comb asm_shift = {asm_q[PIX_W-DATA_W-1:0], DATA};
    end else begin : g_lsb
      always_comb asm_shift = {DATA, asm_q[PIX_W-1:DATA_W]};
    end
  endgenerate

  // A VSYNC rise while HREF is still high ends the line on that same edge.
  always_comb begin
    vsync_rise = CMOS_VSYNC & ~vsync_q;
    capture    = (state_q == S_FRAME) && CMOS_HREF && !vsync_rise;
    line_end   = (state_q == S_FRAME) && line_seen_q &&
                 ((href_q && !CMOS_HREF) || (vsync_rise && CMOS_HREF));
  end

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    x_d          = x_q;
    y_d          = y_q;
    xovf_d       = xovf_q;
    yovf_d       = yovf_q;
    line_seen_d  = line_seen_q;
    asm_d        = asm_q;
    pix_data_d   = pix_data_q;
    pix_x_d      = pix_x_q;
    pix_y_d      = pix_y_q;
    pix_valid_d  = 1'b0;
    sof_d        = 1'b0;
    eol_d        = 1'b0;
    line_err_d   = 1'b0;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;

    case (state_q)
      S_IDLE, S_VSYNC: begin
        phase_d     = '0;
        x_d         = '0;
        y_d         = '0;
        xovf_d      = 1'b0;
        yovf_d      = 1'b0;
        line_seen_d = 1'b0;
        if (state_q == S_IDLE && CMOS_VSYNC)       state_d = S_VSYNC;
        else if (state_q == S_VSYNC && !CMOS_VSYNC) state_d = S_FRAME;
      end
      S_FRAME: begin
        if (!CMOS_HREF) phase_d = '0;
        if (capture) begin
          line_seen_d = 1'b1;
          asm_d       = asm_shift;
          if (phase_q == PH_LAST) begin
            phase_d = '0;
            if (x_q < X_LIM) begin
              x_d = x_q + (XW+1)'(1);
              if (y_q < Y_LIM) begin
                pix_valid_d = 1'b1;
                pix_data_d  = asm_shift;
                pix_x_d     = x_q[XW-1:0];
                pix_y_d     = y_q[YW-1:0];
                sof_d       = (x_q == '0) && (y_q == '0);
                eol_d       = (x_q == X_LAST);
              end
            end else begin
              xovf_d = 1'b1;
            end
          end else begin
            phase_d = phase_q + PHW'(1);
          end
        end
        if (line_end) begin
          line_err_d  = (phase_q != '0) || (x_q != X_LIM) || xovf_q;
          phase_d     = '0;
          x_d         = '0;
          xovf_d      = 1'b0;
          line_seen_d = 1'b0;
          if (y_q < Y_LIM) y_d = y_q + (YW+1)'(1);
          else             yovf_d = 1'b1;
        end
        if (vsync_rise) begin
          frame_done_d = 1'b1;
          frame_err_d  = (y_d != Y_LIM) || yovf_d;
          state_d      = S_VSYNC;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CMOS_oCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q      <= S_IDLE;
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      phase_q      <= '0;
      x_q          <= '0;
      y_q          <= '0;
      xovf_q       <= 1'b0;
      yovf_q       <= 1'b0;
      line_seen_q  <= 1'b0;
      asm_q        <= '0;
      pix_data_q   <= '0;
      pix_valid_q  <= 1'b0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      sof_q        <= 1'b0;
      eol_q        <= 1'b0;
      frame_done_q <= 1'b0;
      line_err_q   <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      vsync_q      <= CMOS_VSYNC;
      href_q       <= CMOS_HREF;
      phase_q      <= phase_d;
      x_q          <= x_d;
      y_q          <= y_d;
      xovf_q       <= xovf_d;
      yovf_q       <= yovf_d;
      line_seen_q  <= line_seen_d;
      asm_q        <= asm_d;
      pix_data_q   <= pix_data_d;
      pix_valid_q  <= pix_valid_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      sof_q        <= sof_d;
      eol_q        <= eol_d;
      frame_done_q <= frame_done_d;
      line_err_q   <= line_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_comb begin
    pix_data   = pix_data_q;
    pix_valid  = pix_valid_q;
    pix_x      = pix_x_q;
    pix_y      = pix_y_q;
    sof        = sof_q;
    eol        = eol_q;
    frame_done = frame_done_q;
    line_err   = line_err_q;
    frame_err  = frame_err_q;
  end

endmodule

// File: tb/tb_cmos_pixel_packer.sv
// Scoreboard bench: two packer configurations driven with random/ramp byte
// streams; expected pixels and line/frame events come from a byte-list model.
module tb_cmos_pixel_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       vs [2];
  logic       hr [2];
  logic [7:0] dt [2];
  longint     cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] pd0; logic [2:0] px0; logic [1:0] py0;
  logic        pv0, so0, eo0, fd0, le0, fe0;
  logic [23:0] pd1; logic [1:0] px1; logic [1:0] py1;
  logic        pv1, so1, eo1, fd1, le1, fe1;

  cmos_pixel_packer #(.DATA_W(8), .BYTES_PER_PIX(2), .MSB_FIRST(1),
                      .H_ACTIVE(8), .V_ACTIVE(4)) u_dut0 (
    .CMOS_oCLK(clk), .iRST_N(rst_n), .CMOS_VSYNC(vs[0]), .CMOS_HREF(hr[0]),
    .DATA(dt[0]), .pix_data(pd0), .pix_valid(pv0), .pix_x(px0), .pix_y(py0),
    .sof(so0), .eol(eo0), .frame_done(fd0), .line_err(le0), .frame_err(fe0));

  cmos_pixel_packer #(.DATA_W(8), .BYTES_PER_PIX(3), .MSB_FIRST(0),
                      .H_ACTIVE(4), .V_ACTIVE(3)) u_dut1 (
    .CMOS_oCLK(clk), .iRST_N(rst_n), .CMOS_VSYNC(vs[1]), .CMOS_HREF(hr[1]),
    .DATA(dt[1]), .pix_data(pd1), .pix_valid(pv1), .pix_x(px1), .pix_y(py1),
    .sof(so1), .eol(eo1), .frame_done(fd1), .line_err(le1), .frame_err(fe1));

  function automatic int bpp_of(int d); return (d == 0) ? 2 : 3; endfunction
  function automatic int msb_of(int d); return (d == 0) ? 1 : 0; endfunction
  function automatic int h_of(int d);   return (d == 0) ? 8 : 4; endfunction
  function automatic int v_of(int d);   return (d == 0) ? 4 : 3; endfunction

  typedef struct {
    int          kind;   // 0 pixel, 1 line_err, 2 frame_done
    int          dut;
    logic [31:0] data;
    int          x;
    int          y;
    bit          sof;
    bit          eol;
    bit          err;
    longint      cyc;
  } ev_t;

  ev_t        expq [$];
  bit         fr_act [2];
  int         lines [2];
  logic [7:0] lb [$];
  int         checks = 0;
  int         failures = 0;

  task automatic push_ev(int kind, int d, logic [31:0] data, int x, int y,
                         bit so, bit eo, bit err, longint c);
    ev_t e;
    e.kind = kind; e.dut = d; e.data = data; e.x = x; e.y = y;
    e.sof = so; e.eol = eo; e.err = err; e.cyc = c;
    expq.push_back(e);
  endtask

  task automatic mon(int d, bit pv, logic [31:0] pd, int px, int py,
                     bit so, bit eo, bit le, bit fd, bit fe);
    ev_t e;
    if (pv) begin
      checks++;
      if (expq.size() == 0) begin
        failures++;
        $display("FAIL pix_unexpected dut%0d: got data=%h x=%0d y=%0d, required no pixel", d, pd, px, py);
      end else begin
        e = expq.pop_front();
        if (e.kind != 0 || e.dut != d || e.data != pd || e.x != px || e.y != py ||
            e.sof != so || e.eol != eo || e.cyc != cyc) begin
          failures++;
          $display("FAIL pixel dut%0d: got data=%h x=%0d y=%0d sof=%0b eol=%0b cyc=%0d, required kind=%0d dut%0d data=%h x=%0d y=%0d sof=%0b eol=%0b cyc=%0d",
                   d, pd, px, py, so, eo, cyc, e.kind, e.dut, e.data, e.x, e.y, e.sof, e.eol, e.cyc);
        end
      end
    end else if (so || eo) begin
      checks++; failures++;
      $display("FAIL marker_no_valid dut%0d: got sof=%0b eol=%0b with pix_valid=0, required 0", d, so, eo);
    end
    if (le) begin
      checks++;
      if (expq.size() == 0) begin
        failures++;
        $display("FAIL line_err_unexpected dut%0d: got line_err=1 cyc=%0d, required 0", d, cyc);
      end else begin
        e = expq.pop_front();
        if (e.kind != 1 || e.dut != d || e.cyc != cyc) begin
          failures++;
          $display("FAIL line_err dut%0d: got line_err at cyc=%0d, required kind=%0d dut%0d cyc=%0d", d, cyc, e.kind, e.dut, e.cyc);
        end
      end
    end
    if (fd) begin
      checks++;
      if (expq.size() == 0) begin
        failures++;
        $display("FAIL frame_done_unexpected dut%0d: got frame_done=1 cyc=%0d, required 0", d, cyc);
      end else begin
        e = expq.pop_front();
        if (e.kind != 2 || e.dut != d || e.err != fe || e.cyc != cyc) begin
          failures++;
          $display("FAIL frame_done dut%0d: got frame_err=%0b cyc=%0d, required kind=%0d dut%0d frame_err=%0b cyc=%0d", d, fe, cyc, e.kind, e.dut, e.err, e.cyc);
        end
      end
    end else if (fe) begin
      checks++; failures++;
      $display("FAIL frame_err_alone dut%0d: got frame_err=1 without frame_done, required 0", d);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, pv0, 32'(pd0), int'(px0), int'(py0), so0, eo0, le0, fd0, fe0);
      mon(1, pv1, 32'(pd1), int'(px1), int'(py1), so1, eo1, le1, fd1, fe1);
    end
  end

  task automatic check_zero(string name);
    checks++;
    if ({pv0, pd0, px0, py0, so0, eo0, fd0, le0, fe0,
         pv1, pd1, px1, py1, so1, eo1, fd1, le1, fe1} != '0) begin
      failures++;
      $display("FAIL %s: got dut0 pv=%0b data=%h fd=%0b le=%0b dut1 pv=%0b data=%h fd=%0b le=%0b, required all 0",
               name, pv0, pd0, fd0, le0, pv1, pd1, fd1, le1);
    end
  endtask

  task automatic drive(int d, bit v, bit h, logic [7:0] b);
    @(negedge clk);
    vs[d] = v; hr[d] = h; dt[d] = b;
  endtask

  task automatic put_byte(int d, logic [7:0] b);
    int n, k, base, bp;
    logic [31:0] pix;
    bp = bpp_of(d);
    drive(d, 1'b0, 1'b1, b);
    lb.push_back(b);
    n = lb.size();
    if (fr_act[d] && (n % bp) == 0) begin
      k = n / bp - 1;
      if (k < h_of(d) && lines[d] < v_of(d)) begin
        base = n - bp;
        pix = '0;
        for (int j = 0; j < bp; j++) begin
          if (msb_of(d) != 0) pix = (pix << 8) | 32'(lb[base+j]);
          else                pix = pix | (32'(lb[base+j]) << (8*j));
        end
        push_ev(0, d, pix, k, lines[d], (k == 0 && lines[d] == 0),
                (k == h_of(d) - 1), 1'b0, cyc + 1);
      end
    end
  endtask

  task automatic end_line(int d, bit cut);
    int n;
    bit err;
    n = lb.size();
    if (cut) drive(d, 1'b1, 1'b1, 8'($urandom_range(0, 255)));
    else     drive(d, 1'b0, 1'b0, 8'h00);
    if (fr_act[d] && n > 0) begin
      err = (n % bpp_of(d) != 0) || (n / bpp_of(d) != h_of(d));
      if (err) push_ev(1, d, '0, 0, 0, 1'b0, 1'b0, 1'b1, cyc + 1);
      lines[d]++;
    end
    if (cut) begin
      if (fr_act[d]) push_ev(2, d, '0, 0, 0, 1'b0, 1'b0, lines[d] != v_of(d), cyc + 1);
      drive(d, 1'b1, 1'b0, 8'h00);
      drive(d, 1'b0, 1'b0, 8'h00);
      fr_act[d] = 1'b1;
      lines[d]  = 0;
    end
    lb.delete();
    repeat (3) drive(d, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic send_line(int d, int n, bit ramp, bit cut);
    for (int i = 0; i < n; i++)
      put_byte(d, ramp ? 8'(i) : 8'($urandom_range(0, 255)));
    end_line(d, cut);
  endtask

  task automatic send_vsync(int d);
    drive(d, 1'b1, 1'b0, 8'h00);
    if (fr_act[d]) push_ev(2, d, '0, 0, 0, 1'b0, 1'b0, lines[d] != v_of(d), cyc + 1);
    drive(d, 1'b1, 1'b0, 8'h00);
    drive(d, 1'b0, 1'b0, 8'h00);
    drive(d, 1'b0, 1'b0, 8'h00);
    fr_act[d] = 1'b1;
    lines[d]  = 0;
  endtask

  task automatic random_frames(int d, int nframes);
    int nl, len;
    for (int f = 0; f < nframes; f++) begin
      nl = $urandom_range(v_of(d) - 1, v_of(d) + 1);
      for (int l = 0; l < nl; l++) begin
        len = ($urandom_range(0, 1) == 0) ? h_of(d) * bpp_of(d)
                                          : $urandom_range(1, h_of(d) * bpp_of(d) + 6);
        send_line(d, len, 1'b0, 1'b0);
      end
      send_vsync(d);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      vs[d] = 1'b0; hr[d] = 1'b0; dt[d] = 8'h00; fr_act[d] = 1'b0; lines[d] = 0;
    end
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    rst_n = 1'b1;

    // Bytes before the first VSYNC are ignored.
    send_line(0, 16, 1'b0, 1'b0);
    send_vsync(0);
    for (int l = 0; l < 4; l++) send_line(0, 16, 1'b1, 1'b0);
    send_vsync(0);

    // Odd line, good line, long line, then one line too many.
    send_line(0, 15, 1'b0, 1'b0);
    send_line(0, 16, 1'b0, 1'b0);
    send_line(0, 20, 1'b0, 1'b0);
    send_line(0, 16, 1'b0, 1'b0);
    send_line(0, 16, 1'b0, 1'b0);
    send_vsync(0);

    random_frames(0, 3);

    // Line cut short by VSYNC, then a clean frame restarting at (0,0).
    send_line(0, 7, 1'b0, 1'b1);
    for (int l = 0; l < 4; l++) send_line(0, 16, 1'b0, 1'b0);
    send_vsync(0);

    // Reset in the middle of a line.
    for (int i = 0; i < 5; i++) put_byte(0, 8'($urandom_range(0, 255)));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("reset_mid_line");
    for (int d = 0; d < 2; d++) begin fr_act[d] = 1'b0; lines[d] = 0; end
    lb.delete();
    repeat (3) drive(0, 1'b0, 1'b1, 8'($urandom_range(0, 255)));
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) put_byte(0, 8'($urandom_range(0, 255)));
    end_line(0, 1'b0);
    send_line(0, 16, 1'b0, 1'b0);
    send_vsync(0);
    for (int l = 0; l < 4; l++) send_line(0, 16, 1'b0, 1'b0);
    send_vsync(0);

    // Three-byte, LSB-first configuration.
    send_vsync(1);
    for (int l = 0; l < 3; l++) send_line(1, 12, 1'b1, 1'b0);
    send_vsync(1);
    send_line(1, 13, 1'b0, 1'b0);
    send_line(1, 12, 1'b0, 1'b0);
    send_line(1, 12, 1'b0, 1'b0);
    send_vsync(1);
    send_line(1, 18, 1'b0, 1'b0);
    for (int l = 0; l < 3; l++) send_line(1, 12, 1'b0, 1'b0);
    send_vsync(1);
    random_frames(1, 3);
    send_line(1, 5, 1'b0, 1'b1);
    for (int l = 0; l < 3; l++) send_line(1, 12, 1'b0, 1'b0);
    send_vsync(1);

    repeat (5) @(negedge clk);
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d expected events never emitted (first kind=%0d dut%0d cyc=%0d), required 0",
               expq.size(), expq[0].kind, expq[0].dut, expq[0].cyc);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
